result_capture: RTL and testbench
=================================

Name: result_capture

Overview:
- Sink-side counterpart of the packed-vector ROM sources that feed the systolic array.
- Accepts packed row vectors (SIZE lanes of DATA_WIDTH) from the array output, buffers ROWS of them, then drains them element by element over a valid/ready stream to a host or checker.
- Lane packing matches the source side: lane t = data_in[DATA_WIDTH*t +: DATA_WIDTH].

Parameters:
- DATA_WIDTH, 8, element width in bits
- SIZE, 16, lanes per packed row
- ROWS, 16, rows buffered per frame (>=2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: arm a new capture frame
- in_valid  input  1  data_in holds a valid row
- in_ready  output  1  block accepts a row this cycle
- data_in  input  DATA_WIDTH*SIZE  packed row, lane t at [DATA_WIDTH*t +: DATA_WIDTH]
- rd_valid  output  1  rd_data valid
- rd_ready  input  1  downstream accepts rd_data
- rd_data  output  DATA_WIDTH  current drained element
- rd_last  output  1  high with the final element of the frame
- done  output  1  frame fully drained; held until next start
- overflow  output  1  sticky: in_valid seen while not ready in CAPTURE; cleared by start

Behaviour:
- Reset (async, active-high) values: state=IDLE, in_ready=0, rd_valid=0, rd_data=0, rd_last=0, done=0, overflow=0, all counters 0. Memory contents are not reset.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE --start--> CAPTURE
  - CAPTURE --ROWS-th row accepted--> DRAIN
  - DRAIN --last element handshaked--> DONE
  - DONE --start--> CAPTURE
  - A start pulse in CAPTURE or DRAIN aborts the frame: counters and overflow clear, state goes to CAPTURE, done=0.
- CAPTURE:
  - in_ready=1 combinationally while wr_row < ROWS.
  - A transfer occurs when in_valid && in_ready: the row is stored at mem[wr_row] on that edge and wr_row increments.
  - Acceptance is at most one row per cycle, with zero bubble.
- Transition latency: the cycle after the ROWS-th accept, state=DRAIN and in_ready=0.
- DRAIN:
  - Order is row-major, lane 0 first: element (r,c) = mem[r][DATA_WIDTH*c +: DATA_WIDTH].
  - rd_data/rd_valid are registered. The first element appears 1 cycle after entering DRAIN.
  - On rd_valid && rd_ready, the next element is presented on the following cycle, so a back-to-back stream runs at 1 element/cycle.
  - If rd_ready=0, rd_data, rd_valid and rd_last hold stable.
  - rd_last=1 only on element (ROWS-1, SIZE-1).
- DONE:
  - rd_valid=0 and done=1.
  - in_ready=0, and in_valid is ignored without setting overflow.
- Counter rules:
  - Column counter wraps SIZE-1 -> 0 and increments the row counter.
  - Counter widths are $clog2 of ROWS/SIZE, with +1 bit on wr_row to represent the value ROWS.
- overflow: set when in_valid=1 && in_ready=0 && state==CAPTURE, which can only happen under the WRAP-disabled full edge case. It stays set until start or reset.
- Reset mid-drain: all outputs return to reset values immediately (async). No partial frame survives.

Optional Feature:
- Macro RESULT_CAPTURE_WRAP_EN.
- Defined: CAPTURE becomes a circular buffer.
  - in_ready stays 1, and wr_row wraps ROWS-1 -> 0, overwriting the oldest row.
  - The transition to DRAIN instead requires a one-cycle `flush` input pulse, which adds a port in this build only.
  - Drain starts at the oldest row (wr_row) and walks ROWS rows modulo ROWS.
  - overflow stays 0.
- Undefined: behaviour exactly as in Behaviour; there is no flush port.

Decomposition:
- Shared package systolic_pkg:
  - capture state enum typedef (IDLE/CAPTURE/DRAIN/DONE)
  - localparam helpers for lane slicing (lane index width)
  - default DATA_WIDTH/SIZE constants shared with the ROM sources
- One natural sub-module: result_capture_mem, a ROWS x (DATA_WIDTH*SIZE) register array with a write port and a combinational row/lane read mux. The FSM and counters stay in result_capture.

Test Plan:
- Basic frame, DATA_WIDTH=8, SIZE=4, ROWS=2:
  - Stimulus: start, then rows 0x44332211 and 0x88776655 back-to-back, rd_ready=1.
  - Required response: rd_data sequence 11,22,33,44,55,66,77,88; rd_last only on 88; done=1 the cycle after; in_ready=0 after the 2nd row.
- Drain backpressure:
  - Stimulus: rd_ready toggles 1,0,0,1 during the drain.
  - Required response: rd_data/rd_last stable while rd_ready=0; no element skipped or duplicated; total 8 handshakes.
- Input gaps:
  - Stimulus: in_valid pulsed with 3 idle cycles between rows.
  - Required response: wr_row advances only on handshakes; drain content identical to the basic frame.
- Abort:
  - Stimulus: start again after 1 row captured.
  - Required response: counters cleared; the next 2 rows form the frame; the first row is never drained.
- Async reset mid-drain:
  - Stimulus: assert reset between clock edges after 3 elements.
  - Required response: rd_valid, rd_data, done, overflow and in_ready go to 0 immediately.
  - Then start plus a full frame completes correctly.
- WRAP_EN build:
  - Stimulus: capture 3 rows A,B,C with ROWS=2, then flush.
  - Required response: drain order is B lanes then C lanes; overflow=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array sources and sinks: capture FSM
// states, default geometry shared with the ROM sources, and an index-width
// helper used to size lane and row counters.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_SIZE       = 16;
    localparam int DEFAULT_ROWS       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/result_capture_mem.sv
// Row buffer for result_capture: ROWS packed rows, one synchronous write port
// and a combinational row/lane read mux. Contents are intentionally not reset.
module result_capture_mem
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int RW         = idx_width(ROWS),
    parameter int CW         = idx_width(SIZE)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [RW-1:0]              waddr,
    input  logic [DATA_WIDTH*SIZE-1:0] wdata,
    input  logic [RW-1:0]              rrow,
    input  logic [CW-1:0]              rlane,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH*SIZE-1:0] mem_r [ROWS];

    // Store an accepted row at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[rrow][DATA_WIDTH*rlane +: DATA_WIDTH];

endmodule

// File: rtl/result_capture.sv
// result_capture: buffers ROWS packed row vectors coming out of the systolic
// array, then drains them element by element (row-major, lane 0 first) over a
// valid/ready stream.
// Optional build macro RESULT_CAPTURE_WRAP_EN: capture becomes a circular
// buffer, a flush pulse starts the drain, and the drain begins at the oldest row.
module result_capture
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int ROWS       = DEFAULT_ROWS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
`ifdef RESULT_CAPTURE_WRAP_EN
    input  logic                       flush,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*SIZE-1:0] data_in,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_last,
    output logic                       done,
    output logic                       overflow
);

    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(SIZE);

    localparam logic [RW:0]   WR_ONE     = (RW+1)'(1);
    localparam logic [RW:0]   WR_ROWS    = (RW+1)'(ROWS);
    localparam logic [RW:0]   WR_LAST    = (RW+1)'(ROWS-1);
    localparam logic [RW-1:0] RD_ONE     = RW'(1);
    localparam logic [RW-1:0] RD_LAST    = RW'(ROWS-1);
    localparam logic [CW-1:0] COL_ONE    = CW'(1);
    localparam logic [CW-1:0] COL_LAST   = CW'(SIZE-1);
    localparam logic [RW+1:0] SUM_ROWS   = (RW+2)'(ROWS);

    capture_state_t          state_r;
    capture_state_t          state_nxt_s;

    logic [RW:0]             wr_row_r;
    logic [RW-1:0]           rd_row_r;
    logic [CW-1:0]           rd_col_r;
    logic                    rd_valid_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic                    rd_last_r;
    logic                    done_r;
    logic                    overflow_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    frame_full_s;
    logic                    flush_s;
    logic                    load_s;
    logic                    last_hs_s;
    logic [RW+1:0]           row_sum_s;
    logic [RW-1:0]           phys_row_s;
    logic [DATA_WIDTH-1:0]   elem_s;

    // Capture-side handshake decode; the circular build never back-pressures.
    always_comb begin
        in_ready_s   = 1'b0;
        frame_full_s = 1'b0;
        flush_s      = 1'b0;
`ifdef RESULT_CAPTURE_WRAP_EN
        in_ready_s   = (state_r == ST_CAPTURE);
        flush_s      = flush && (state_r == ST_CAPTURE) && !start;
        accept_s     = in_valid && in_ready_s && !start;
`else
        in_ready_s   = (state_r == ST_CAPTURE) && (wr_row_r < WR_ROWS);
        accept_s     = in_valid && in_ready_s && !start;
        frame_full_s = accept_s && (wr_row_r == WR_LAST);
`endif
    end

    // Drain-side decode: load a new element when the output register is
    // empty or is being consumed, and finish on the last handshake.
    always_comb begin
        load_s    = 1'b0;
        last_hs_s = 1'b0;
        if ((state_r == ST_DRAIN) && !start) begin
            load_s    = !rd_valid_r || (rd_ready && !rd_last_r);
            last_hs_s = rd_valid_r && rd_ready && rd_last_r;
        end else begin
            load_s    = 1'b0;
            last_hs_s = 1'b0;
        end
    end

    // Physical row = (oldest row + logical drain row) mod ROWS. Without
    // wrapping, wr_row sits at ROWS during the drain so this reduces to rd_row.
    always_comb begin
        row_sum_s = (RW+2)'(wr_row_r) + (RW+2)'(rd_row_r);
        if (row_sum_s >= SUM_ROWS) begin
            phys_row_s = RW'(row_sum_s - SUM_ROWS);
        end else begin
            phys_row_s = RW'(row_sum_s);
        end
    end

    result_capture_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE),
        .ROWS       (ROWS),
        .RW         (RW),
        .CW         (CW)
    ) u_mem (
        .clk   (clk),
        .we    (accept_s),
        .waddr (wr_row_r[RW-1:0]),
        .wdata (data_in),
        .rrow  (phys_row_s),
        .rlane (rd_col_r),
        .rdata (elem_s)
    );

    // Next-state logic; start always re-arms a fresh frame.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_CAPTURE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (frame_full_s || flush_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_DRAIN: begin
                    if (last_hs_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write row pointer: counts accepted rows, wrapping in the circular build.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row_r <= {(RW+1){1'b0}};
        end else if (start) begin
            wr_row_r <= {(RW+1){1'b0}};
        end else if (accept_s) begin
`ifdef RESULT_CAPTURE_WRAP_EN
            if (wr_row_r == WR_LAST) begin
                wr_row_r <= {(RW+1){1'b0}};
            end else begin
                wr_row_r <= wr_row_r + WR_ONE;
            end
`else
            wr_row_r <= wr_row_r + WR_ONE;
`endif
        end
    end

    // Drain counters and the registered output element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_row_r   <= {RW{1'b0}};
            rd_col_r   <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_last_r  <= 1'b0;
        end else if (start) begin
            rd_row_r   <= {RW{1'b0}};
            rd_col_r   <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_last_r  <= 1'b0;
        end else if (load_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= elem_s;
            rd_last_r  <= (rd_row_r == RD_LAST) && (rd_col_r == COL_LAST);
            if (rd_col_r == COL_LAST) begin
                rd_col_r <= {CW{1'b0}};
                rd_row_r <= rd_row_r + RD_ONE;
            end else begin
                rd_col_r <= rd_col_r + COL_ONE;
            end
        end else if (last_hs_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end
    end

    // Status flags: done follows the DONE state, overflow is sticky until start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (start) begin
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_CAPTURE) && in_valid && !in_ready_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign in_ready = in_ready_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_last  = rd_last_r;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_result_capture.sv
// Self-checking bench for result_capture with DATA_WIDTH=8, SIZE=4, ROWS=2.
// Expected drain streams come from a lane-unpacking model of the captured rows.
module tb_result_capture;

    localparam int DW = 8;
    localparam int SZ = 4;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DW*SZ-1:0] data_in;
    logic            rd_valid;
    logic            rd_ready;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            done;
    logic            overflow;
`ifdef RESULT_CAPTURE_WRAP_EN
    logic            flush;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] row0;
        logic [31:0] row1;
        int          gap;
        logic [3:0]  rdy;
        logic [63:0] exp_stream;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    result_capture #(
        .DATA_WIDTH (DW),
        .SIZE       (SZ),
        .ROWS       (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef RESULT_CAPTURE_WRAP_EN
        .flush    (flush),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .done     (done),
        .overflow (overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream of two rows unpacked lane by lane, lane 0 first, element k at byte k.
    function automatic logic [63:0] model_stream(input logic [31:0] r0, input logic [31:0] r1);
        logic [63:0] s;
        logic [31:0] row;
        s = 64'h0;
        for (int r = 0; r < 2; r++) begin
            row = (r == 0) ? r0 : r1;
            for (int c = 0; c < SZ; c++) begin
                s = s | (64'((row >> (8 * c)) & 32'hFF) << (8 * (SZ * r + c)));
            end
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] row, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        chk("in_ready_capture", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        data_in  = row;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic enter_drain();
`ifdef RESULT_CAPTURE_WRAP_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
`endif
        chk("in_ready_drain", 64'(in_ready), 64'd0);
        chk("rd_valid_drain_entry", 64'(rd_valid), 64'd0);
    endtask

    // Drain with a cyclic ready pattern; stop after n_stop handshakes.
    task automatic drain(input logic [63:0] exp_s, input logic [3:0] rdy, input int n_stop);
        int k;
        int cyc;
        logic [7:0] e;
        k   = 0;
        cyc = 0;
        while (k < n_stop && cyc < 200) begin
            rd_ready = rdy[cyc % 4];
            if (cyc == 1) begin
                chk("first_elem_latency", 64'(rd_valid), 64'd1);
            end
            if (rd_valid) begin
                e = exp_s[8*k +: 8];
                chk("rd_data", 64'(rd_data), 64'(e));
                chk("rd_last", 64'(rd_last), 64'(k == 2 * SZ - 1));
                if (rd_ready) begin
                    k++;
                end
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        if (k < n_stop) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout handshakes=%0d required=%0d", k, n_stop);
        end else if (n_stop == 2 * SZ) begin
            chk("done_after_last", 64'(done), 64'd1);
            chk("rd_valid_after_last", 64'(rd_valid), 64'd0);
            chk("overflow_clear", 64'(overflow), 64'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        do_start();
        feed(v.row0, v.gap);
        feed(v.row1, v.gap);
        enter_drain();
        drain(v.exp_stream, v.rdy, 2 * SZ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rc;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        rd_ready = 1'b0;
        data_in  = 32'h0;
`ifdef RESULT_CAPTURE_WRAP_EN
        flush    = 1'b0;
`endif
        repeat (2) tick();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_last", 64'(rd_last), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();

        // IDLE ignores input rows.
        in_valid = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_overflow", 64'(overflow), 64'd0);
        in_valid = 1'b0;

        // Directed and randomized frame table.
        vecs[0] = '{32'h44332211, 32'h88776655, 0, 4'b1111, 64'h8877665544332211};
        vecs[1] = '{32'h44332211, 32'h88776655, 0, 4'b1001, 64'h8877665544332211};
        vecs[2] = '{32'h44332211, 32'h88776655, 3, 4'b1111, 64'h8877665544332211};
        vecs[3] = '{32'hDEADBEEF, 32'h01020304, 1, 4'b0110, 64'h01020304DEADBEEF};
        for (int i = 4; i < 8; i++) begin
            vecs[i].row0 = $urandom();
            vecs[i].row1 = $urandom();
            vecs[i].gap  = int'($urandom_range(0, 3));
            vecs[i].rdy  = 4'($urandom_range(0, 15)) | 4'b0001;
            vecs[i].exp_stream = model_stream(vecs[i].row0, vecs[i].row1);
        end
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // DONE ignores in_valid and keeps done asserted.
        in_valid = 1'b1;
        repeat (2) tick();
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("done_overflow", 64'(overflow), 64'd0);
        chk("done_held", 64'(done), 64'd1);
        in_valid = 1'b0;

        // Abort after one row: that row must never be drained.
        ra = $urandom();
        rb = $urandom();
        do_start();
        feed(32'hCAFEF00D, 0);
        do_start();
        chk("abort_done_clear", 64'(done), 64'd0);
        feed(ra, 0);
        feed(rb, 0);
        enter_drain();
        drain(model_stream(ra, rb), 4'b1111, 2 * SZ);

        // Async reset mid-drain after three elements.
        do_start();
        feed(32'h44332211, 0);
        feed(32'h88776655, 0);
        enter_drain();
        drain(64'h8877665544332211, 4'b1111, 3);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_rd_valid", 64'(rd_valid), 64'd0);
        chk("areset_rd_data", 64'(rd_data), 64'd0);
        chk("areset_done", 64'(done), 64'd0);
        chk("areset_overflow", 64'(overflow), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_vec(vecs[3]);

`ifdef RESULT_CAPTURE_WRAP_EN
        // Circular capture: three rows into two slots, oldest surviving row first.
        ra = $urandom();
        rb = $urandom();
        rc = $urandom();
        do_start();
        feed(ra, 0);
        feed(rb, 0);
        feed(rc, 1);
        enter_drain();
        drain(model_stream(rb, rc), 4'b1011, 2 * SZ);
`else
        rc = 32'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
